// File: rtl/uart_cmd_master.sv
// Purpose: UART command master. Sends CMD_BYTES command bytes, then for reads collects RD_BYTES reply bytes.
// Latency: a write frees cmd_rdy CMD_BYTES*frame*CLK_DIV + (CMD_BYTES-1)*GAP_BITS*CLK_DIV + 2 cycles after acceptance.
// Backpressure: cmd_rdy is high only in IDLE. The read result is a one-cycle read_vld pulse with no ready.
// Ports: clk/rst (sync, active-high); cmd_in/cmd_vld/cmd_rdy command handshake, cmd_in MSB=1 means write;
//        rx/tx serial lines (idle high); read_data/read_vld/read_err read result, first byte in the MSBs.
module uart_cmd_master #(
  parameter int CMD_BYTES  = 2,
  parameter int RD_BYTES   = 1,
  parameter int CLK_DIV    = 434,
  parameter int PARITY     = 2,
  parameter int GAP_BITS   = 15,
  parameter int RX_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CMD_BYTES*8-1:0] cmd_in,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  rx,
  output logic                  tx,
  output logic [RD_BYTES*8-1:0] read_data,
  output logic                  read_vld,
  output logic                  read_err
);

  localparam int CW     = CMD_BYTES * 8;
  localparam int RW     = RD_BYTES * 8;
  localparam int HALF   = CLK_DIV / 2;
  localparam int TO_CYC = RX_TIMEOUT * CLK_DIV;
  localparam int BW     = $clog2(CLK_DIV);
  localparam int GW     = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int TBW    = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int RBW    = (RD_BYTES > 1) ? $clog2(RD_BYTES) : 1;
  localparam int TOW    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  HALF_LAST = BW'(HALF - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [TBW-1:0] TXB_LAST  = TBW'(CMD_BYTES - 1);
  localparam logic [RBW-1:0] RXB_LAST  = RBW'(RD_BYTES - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TO_CYC - 1);
  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 1);
  localparam logic GAP_EN  = (GAP_BITS != 0);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, TX_GAP,
    RX_WAIT, RX_START, RX_DATA, RX_PAR, RX_STOP, DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]  cmd_reg;
  logic           is_wr;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [TBW-1:0] txb_cnt;
  logic [RBW-1:0] rxb_cnt;
  logic [TOW-1:0] to_cnt;
  logic           rx_s1, rx_s2, rx_prev;
  logic [7:0]     rx_sh;
  logic [RW-1:0]  rd_buf;
  logic           err_flag;

  logic           tick, rx_fall, tx_last, rx_last, timed_out, in_rx, par_bad;
  logic [7:0]     tx_byte;
  logic           tx_par;
  logic [RW-1:0]  rd_buf_n;

  assign tick      = (baud_cnt == '0);
  assign rx_fall   = rx_prev & ~rx_s2;
  assign tx_last   = (txb_cnt == TXB_LAST);
  assign rx_last   = (rxb_cnt == RXB_LAST);
  assign timed_out = (to_cnt == TO_LAST);
  assign in_rx     = (state == RX_WAIT) || (state == RX_START) || (state == RX_DATA) ||
                     (state == RX_PAR)  || (state == RX_STOP);
  // The byte on the wire is always the top byte; cmd_reg shifts left after each stop bit.
  assign tx_byte   = cmd_reg[CW-1 -: 8];
  assign tx_par    = (^tx_byte) ^ PAR_ODD;
  // Even parity: data plus parity has an even number of ones; odd mode inverts that.
  assign par_bad   = (^{rx_sh, rx_s2}) ^ PAR_ODD;
  assign rd_buf_n  = (rd_buf << 8) | RW'(rx_sh);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (cmd_vld) state_n = TX_START;
      TX_START: if (tick) state_n = TX_DATA;
      TX_DATA:  if (tick && bit_cnt == 3'd7) state_n = PAR_EN ? TX_PAR : TX_STOP;
      TX_PAR:   if (tick) state_n = TX_STOP;
      TX_STOP: begin
        if (tick) begin
          if (!tx_last) state_n = GAP_EN ? TX_GAP : TX_START;
          else          state_n = is_wr ? DONE : RX_WAIT;
        end
      end
      TX_GAP:   if (tick && gap_cnt == GAP_LAST) state_n = TX_START;
      RX_WAIT: begin
        if (rx_fall)        state_n = RX_START;
        else if (timed_out) state_n = DONE;
      end
      // Start bit still high at mid-bit means a glitch: resume waiting.
      RX_START: if (tick) state_n = rx_s2 ? RX_WAIT : RX_DATA;
      RX_DATA:  if (tick && bit_cnt == 3'd7) state_n = PAR_EN ? RX_PAR : RX_STOP;
      RX_PAR:   if (tick) state_n = RX_STOP;
      RX_STOP:  if (tick) state_n = rx_last ? DONE : RX_WAIT;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_rdy  = 1'b0;
    tx       = 1'b1;
    read_vld = 1'b0;
    case (state)
      IDLE:     cmd_rdy  = 1'b1;
      TX_START: tx       = 1'b0;
      TX_DATA:  tx       = tx_byte[bit_cnt];
      TX_PAR:   tx       = tx_par;
      DONE:     read_vld = ~is_wr;
      default:  ;
    endcase
  end

  // Datapath and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_reg   <= '0;
      is_wr     <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      txb_cnt   <= '0;
      rxb_cnt   <= '0;
      to_cnt    <= '0;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_sh     <= '0;
      rd_buf    <= '0;
      err_flag  <= 1'b0;
      read_data <= '0;
      read_err  <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;

      // Every bit boundary reloads; entering RX_START loads a half bit so later samples land mid-bit.
      if (state_n != state)
        baud_cnt <= (state_n == RX_START) ? HALF_LAST : BAUD_LAST;
      else if (tick)
        baud_cnt <= BAUD_LAST;
      else
        baud_cnt <= baud_cnt - BW'(1);

      if (state_n != state)
        bit_cnt <= '0;
      else if (tick && (state == TX_DATA || state == RX_DATA))
        bit_cnt <= bit_cnt + 3'd1;

      if (state_n != state)
        gap_cnt <= '0;
      else if (tick && state == TX_GAP)
        gap_cnt <= gap_cnt + GW'(1);

      if (state == IDLE && cmd_vld) begin
        cmd_reg  <= cmd_in;
        is_wr    <= cmd_in[CW-1];
        txb_cnt  <= '0;
        rxb_cnt  <= '0;
        err_flag <= 1'b0;
        rd_buf   <= '0;
      end

      if (state == TX_STOP && tick) begin
        cmd_reg <= cmd_reg << 8;
        if (!tx_last) txb_cnt <= txb_cnt + TBW'(1);
      end

      // Timeout runs from the first RX_WAIT entry for the whole read and saturates.
      if (state == TX_STOP && state_n == RX_WAIT)
        to_cnt <= '0;
      else if (in_rx && !timed_out)
        to_cnt <= to_cnt + TOW'(1);

      if (state == RX_DATA && tick)
        rx_sh <= {rx_s2, rx_sh[7:1]};

      if (state == RX_PAR && tick && par_bad)
        err_flag <= 1'b1;

      if (state == RX_STOP && tick) begin
        rd_buf <= rd_buf_n;
        if (!rx_s2) err_flag <= 1'b1;
        if (!rx_last) rxb_cnt <= rxb_cnt + RBW'(1);
        else begin
          read_data <= rd_buf_n;
          read_err  <= err_flag | ~rx_s2;
        end
      end

      if (state == RX_WAIT && state_n == DONE) begin
        read_data <= '0;
        read_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: frame-level model of the serial waveforms and read results.
module tb_uart_cmd_master;

  localparam int CMD_BYTES  = 2;
  localparam int RD_BYTES   = 1;
  localparam int CLK_DIV    = 4;
  localparam int PARITY     = 2;
  localparam int GAP_BITS   = 2;
  localparam int RX_TIMEOUT = 8;
  localparam int FRAME_BITS = 1 + 8 + ((PARITY != 0) ? 1 : 0) + 1;
  localparam int TX_CYC     = CMD_BYTES*FRAME_BITS*CLK_DIV + (CMD_BYTES-1)*GAP_BITS*CLK_DIV;
  localparam int WR_LAT     = TX_CYC + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_in;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        rx;
  logic        tx;
  logic [7:0]  read_data;
  logic        read_vld;
  logic        read_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit exp_tx[$];

  uart_cmd_master #(
    .CMD_BYTES(CMD_BYTES), .RD_BYTES(RD_BYTES), .CLK_DIV(CLK_DIV),
    .PARITY(PARITY), .GAP_BITS(GAP_BITS), .RX_TIMEOUT(RX_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .rx(rx), .tx(tx), .read_data(read_data), .read_vld(read_vld), .read_err(read_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected tx line, one entry per clock starting the cycle after acceptance.
  task automatic build_tx_wave(input logic [15:0] c);
    logic [7:0] b;
    bit bits[$];
    exp_tx.delete();
    for (int i = 0; i < CMD_BYTES; i++) begin
      b = c[15 - 8*i -: 8];
      bits.delete();
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
      bits.push_back(^b);
      bits.push_back(1'b1);
      foreach (bits[j]) repeat (CLK_DIV) exp_tx.push_back(bits[j]);
      if (i < CMD_BYTES-1) repeat (GAP_BITS*CLK_DIV) exp_tx.push_back(1'b1);
    end
  endtask

  task automatic send_cmd(input logic [15:0] c);
    int n = 0;
    while (!cmd_rdy && n < 500) begin step(); n++; end
    cmd_in  = c;
    cmd_vld = 1'b1;
    step();
    cmd_vld = 1'b0;
  endtask

  // frame bit 0 goes on the wire first
  task automatic drive_rx_frame(input logic [10:0] fr);
    for (int i = 0; i < 11; i++) begin
      rx = fr[i];
      repeat (CLK_DIV) step();
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_vld = 1'b0; cmd_in = '0; rx = 1'b1;
    repeat (3) step();
    total_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else pass_cnt++;
    total_cnt++; if (cmd_rdy !== 1'b1) $display("FAIL reset_cmd_rdy: got %b want 1", cmd_rdy); else pass_cnt++;
    total_cnt++; if (read_vld !== 1'b0) $display("FAIL reset_read_vld: got %b want 0", read_vld); else pass_cnt++;
    total_cnt++; if (read_err !== 1'b0) $display("FAIL reset_read_err: got %b want 0", read_err); else pass_cnt++;
    total_cnt++; if (read_data !== 8'h00) $display("FAIL reset_read_data: got %h want 00", read_data); else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  // Write with random rx noise throughout; the write must ignore rx entirely.
  task automatic test_write(input string name, input logic [15:0] c);
    int mism = 0, first_bad = -1, rdy_at = -1, vld_seen = 0;
    bit want;
    logic got_bad = 1'b0;
    build_tx_wave(c);
    send_cmd(c);
    for (int k = 1; k <= WR_LAT + 30 && rdy_at < 0; k++) begin
      want = (k <= exp_tx.size()) ? exp_tx[k-1] : 1'b1;
      if (tx !== want) begin
        if (first_bad < 0) begin first_bad = k; got_bad = tx; end
        mism++;
      end
      if (read_vld) vld_seen++;
      if (cmd_rdy) rdy_at = k;
      else begin
        rx = 1'($urandom_range(0, 1));
        step();
      end
    end
    rx = 1'b1;
    total_cnt++;
    if (mism != 0) $display("FAIL %s_tx_wave: %0d bad cycles, first at %0d got %b want %b", name, mism, first_bad, got_bad, ~got_bad);
    else pass_cnt++;
    total_cnt++;
    if (rdy_at != WR_LAT) $display("FAIL %s_latency: cmd_rdy back at cycle %0d want %0d", name, rdy_at, WR_LAT);
    else pass_cnt++;
    total_cnt++;
    if (vld_seen != 0) $display("FAIL %s_no_read_vld: read_vld high %0d cycles want 0", name, vld_seen);
    else pass_cnt++;
    repeat (3) step();
  endtask

  task automatic test_read(input string name, input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit glitch);
    logic [15:0] c;
    logic        exp_err, got_e, par;
    logic [7:0]  got_d, held;
    int          vld_at = -1;
    c = {1'b0, 15'($urandom)};
    exp_err = bad_par | bad_stop;
    par = (^d) ^ bad_par;
    send_cmd(c);
    repeat (TX_CYC + $urandom_range(0, 4)) step();
    if (glitch) begin
      rx = 1'b0; repeat (2) step();
      rx = 1'b1; repeat (8) step();
    end
    drive_rx_frame({~bad_stop, par, d, 1'b0});
    for (int k = 0; k < 40 && vld_at < 0; k++) begin
      if (read_vld) begin vld_at = k; got_d = read_data; got_e = read_err; end
      else step();
    end
    total_cnt++;
    if (vld_at < 0) $display("FAIL %s_read_vld: no pulse within 40 cycles of frame end", name); else pass_cnt++;
    total_cnt++;
    if (got_d !== d) $display("FAIL %s_data: got %h want %h", name, got_d, d); else pass_cnt++;
    total_cnt++;
    if (got_e !== exp_err) $display("FAIL %s_err: got %b want %b", name, got_e, exp_err); else pass_cnt++;
    step();
    total_cnt++;
    if (read_vld !== 1'b0 || cmd_rdy !== 1'b1)
      $display("FAIL %s_pulse: after pulse read_vld=%b cmd_rdy=%b want 0/1", name, read_vld, cmd_rdy);
    else pass_cnt++;
    repeat (4) step();
    held = read_data;
    total_cnt++;
    if (held !== d || read_err !== exp_err)
      $display("FAIL %s_hold: data %h err %b want %h %b", name, held, read_err, d, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int vld_at = -1;
    int exp_at = TX_CYC + 1 + RX_TIMEOUT*CLK_DIV;
    send_cmd(16'h0012);
    for (int k = 1; k < exp_at + 40 && vld_at < 0; k++) begin
      if (read_vld) vld_at = k;
      else step();
    end
    total_cnt++;
    if (vld_at != exp_at) $display("FAIL timeout_at: read_vld at cycle %0d want %0d", vld_at, exp_at); else pass_cnt++;
    total_cnt++;
    if (read_err !== 1'b1) $display("FAIL timeout_err: got %b want 1", read_err); else pass_cnt++;
    total_cnt++;
    if (read_data !== 8'h00) $display("FAIL timeout_data: got %h want 00", read_data); else pass_cnt++;
    repeat (3) step();
  endtask

  task automatic test_reset_midframe();
    int stuck = 0, mism = 0, first_bad = -1;
    bit want;
    send_cmd(16'h8155);
    repeat (21) step();            // now in the 5th data bit of byte 0x81
    rst = 1'b1;
    step();
    total_cnt++; if (tx !== 1'b1) $display("FAIL midrst_tx: got %b want 1", tx); else pass_cnt++;
    total_cnt++; if (cmd_rdy !== 1'b1) $display("FAIL midrst_cmd_rdy: got %b want 1", cmd_rdy); else pass_cnt++;
    total_cnt++; if (read_vld !== 1'b0) $display("FAIL midrst_read_vld: got %b want 0", read_vld); else pass_cnt++;
    total_cnt++; if (read_err !== 1'b0) $display("FAIL midrst_read_err: got %b want 0", read_err); else pass_cnt++;
    total_cnt++; if (read_data !== 8'h00) $display("FAIL midrst_read_data: got %h want 00", read_data); else pass_cnt++;
    // A command offered while reset is held must not start.
    cmd_in = 16'h8155; cmd_vld = 1'b1;
    repeat (3) begin
      step();
      if (tx !== 1'b1) stuck++;
    end
    total_cnt++;
    if (stuck != 0) $display("FAIL midrst_no_accept: tx low %0d cycles under reset want 0", stuck); else pass_cnt++;
    rst = 1'b0;
    step();
    cmd_vld = 1'b0;
    build_tx_wave(16'h8155);
    for (int k = 1; k <= WR_LAT; k++) begin
      want = (k <= exp_tx.size()) ? exp_tx[k-1] : 1'b1;
      if (tx !== want) begin
        mism++;
        if (first_bad < 0) first_bad = k;
      end
      if (k < WR_LAT) step();
    end
    total_cnt++;
    if (mism != 0) $display("FAIL midrst_retx: %0d bad tx cycles, first at %0d want 0", mism, first_bad); else pass_cnt++;
    total_cnt++;
    if (cmd_rdy !== 1'b1) $display("FAIL midrst_rdy_back: cmd_rdy %b at cycle %0d want 1", cmd_rdy, WR_LAT); else pass_cnt++;
  endtask

  initial begin
    logic [7:0] d;
    test_reset();
    test_write("wr_8155", 16'h8155);
    for (int i = 0; i < 3; i++) test_write("wr_rand", {1'b1, 15'($urandom)});
    test_read("rd_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    test_read("rd_a5_badpar", 8'hA5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      test_read("rd_rand", d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 1'b0);
    end
    test_timeout();
    test_read("rd_glitch_3c", 8'h3C, 1'b0, 1'b0, 1'b1);
    test_read("rd_badstop", 8'($urandom), 1'b0, 1'b1, 1'b0);
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
